// File: rtl/traffic_ctrl_multi.sv
// Multi-approach traffic-light controller: round-robin green with min/max
// green timing, fixed yellow and all-red clearance, and a maintenance flash mode.
module traffic_ctrl_multi #(
  parameter int unsigned N_DIR     = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned GREEN_MIN = 5,
  parameter int unsigned GREEN_MAX = 20,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned FLASH_T   = 4,
  localparam int unsigned DIR_W    = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_DIR-1:0]   sensor,
  input  logic               flash,
  output logic [2*N_DIR-1:0] lights,
  output logic [DIR_W-1:0]   cur_dir,
  output logic [1:0]         state_o
);

  localparam logic [1:0] S_GREEN  = 2'b00;
  localparam logic [1:0] S_YELLOW = 2'b01;
  localparam logic [1:0] S_ALLRED = 2'b10;
  localparam logic [1:0] S_FLASH  = 2'b11;

  localparam logic [CNT_W-1:0] GMIN_LAST   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST   = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_T - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [DIR_W-1:0] cur_dir_q, cur_dir_d;
  logic             phase_q, phase_d;
  logic             force0_q, force0_d;

  logic             other_demand;
  logic             green_done;
  logic [DIR_W-1:0] next_dir;
  logic [DIR_W-1:0] probe;
  logic             found;

  always_comb begin
    other_demand = 1'b0;
    for (int unsigned i = 0; i < N_DIR; i++) begin
      if (DIR_W'(i) != cur_dir_q) other_demand = other_demand | sensor[i];
    end
  end

  assign green_done = (timer_q >= GMIN_LAST) && other_demand &&
                      (!sensor[cur_dir_q] || (timer_q >= GMAX_LAST));

  // First waiting approach after cur_dir in cyclic order; plain successor if none waits.
  always_comb begin
    next_dir = (cur_dir_q == DIR_W'(N_DIR - 1)) ? '0 : cur_dir_q + 1'b1;
    found    = 1'b0;
    probe    = '0;
    for (int unsigned k = 1; k < N_DIR; k++) begin
      probe = DIR_W'((32'(cur_dir_q) + k) % N_DIR);
      if (!found && sensor[probe]) begin
        found    = 1'b1;
        next_dir = probe;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_dir_d = cur_dir_q;
    phase_d   = phase_q;
    force0_d  = force0_q;
    timer_d   = (&timer_q) ? timer_q : timer_q + 1'b1;
    if (flash) begin
      if (state_q != S_FLASH) begin
        state_d = S_FLASH;
        timer_d = '0;
        phase_d = 1'b0;
      end else if (timer_q == FLASH_LAST) begin
        timer_d = '0;
        phase_d = ~phase_q;
      end
    end else begin
      unique case (state_q)
        S_GREEN: if (green_done) begin
          state_d = S_YELLOW;
          timer_d = '0;
        end
        S_YELLOW: if (timer_q == YELLOW_LAST) begin
          state_d = S_ALLRED;
          timer_d = '0;
        end
        S_ALLRED: if (timer_q == ALLRED_LAST) begin
          state_d   = S_GREEN;
          timer_d   = '0;
          force0_d  = 1'b0;
          cur_dir_d = force0_q ? '0 : next_dir;
        end
        default: begin
          state_d  = S_ALLRED;
          timer_d  = '0;
          force0_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_GREEN;
      timer_q   <= '0;
      cur_dir_q <= '0;
      phase_q   <= 1'b0;
      force0_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cur_dir_q <= cur_dir_d;
      phase_q   <= phase_d;
      force0_q  <= force0_d;
    end
  end

  always_comb begin
    lights = '0;
    for (int unsigned i = 0; i < N_DIR; i++) begin
      unique case (state_q)
        S_FLASH:  lights[2*i +: 2] = phase_q ? 2'b11 : 2'b01;
        S_ALLRED: lights[2*i +: 2] = 2'b10;
        S_YELLOW: lights[2*i +: 2] = (DIR_W'(i) == cur_dir_q) ? 2'b01 : 2'b10;
        default:  lights[2*i +: 2] = (DIR_W'(i) == cur_dir_q) ? 2'b00 : 2'b10;
      endcase
    end
  end

  assign cur_dir = cur_dir_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Randomized bench for traffic_ctrl_multi against a behavioural phase/duration
// model of the intersection, plus directed scenarios for the main timing cases.
module tb_traffic_ctrl_multi;

  localparam int N         = 4;
  localparam int GREEN_MIN = 5;
  localparam int GREEN_MAX = 20;
  localparam int YELLOW_T  = 2;
  localparam int ALLRED_T  = 1;
  localparam int FLASH_T   = 4;
  localparam int T_SAT     = 255;

  localparam int MG = 0, MY = 1, MR = 2, MF = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sensor;
  logic       flash;
  logic [7:0] lights;
  logic [1:0] cur_dir;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_errors = 0;

  int m_mode, m_t, m_dir, m_phase, m_force0;

  traffic_ctrl_multi #(
    .N_DIR(N), .CNT_W(8), .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX),
    .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T), .FLASH_T(FLASH_T)
  ) dut (
    .clk(clk), .reset(reset), .sensor(sensor), .flash(flash),
    .lights(lights), .cur_dir(cur_dir), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_mode = MG; m_t = 0; m_dir = 0; m_phase = 0; m_force0 = 0;
  endtask

  function automatic int pick_next();
    for (int k = 1; k < N; k++) begin
      if (sensor[(m_dir + k) % N]) return (m_dir + k) % N;
    end
    return (m_dir + 1) % N;
  endfunction

  function automatic int phase_len(int mode);
    return (mode == MY) ? YELLOW_T : ALLRED_T;
  endfunction

  task automatic m_step();
    bit others;
    int elapsed;
    others = 1'b0;
    for (int k = 0; k < N; k++) if (k != m_dir && sensor[k]) others = 1'b1;
    elapsed = m_t + 1;
    m_t = (m_t < T_SAT) ? m_t + 1 : T_SAT;
    if (flash) begin
      if (m_mode != MF) begin
        m_mode = MF; m_t = 0; m_phase = 0;
      end else if (elapsed == FLASH_T) begin
        m_phase = 1 - m_phase; m_t = 0;
      end
    end else if (m_mode == MF) begin
      m_mode = MR; m_t = 0; m_force0 = 1;
    end else if (m_mode == MG) begin
      if (elapsed >= GREEN_MIN && others && (!sensor[m_dir] || elapsed >= GREEN_MAX)) begin
        m_mode = MY; m_t = 0;
      end
    end else if (elapsed == phase_len(m_mode)) begin
      if (m_mode == MY) begin
        m_mode = MR;
      end else begin
        m_mode = MG;
        m_dir = m_force0 ? 0 : pick_next();
        m_force0 = 0;
      end
      m_t = 0;
    end
  endtask

  function automatic logic [7:0] exp_lights();
    logic [7:0] v;
    int code;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (m_mode == MF)      code = m_phase ? 3 : 1;
      else if (m_mode == MR) code = 2;
      else if (i == m_dir)   code = (m_mode == MG) ? 0 : 1;
      else                   code = 2;
      v[2*i +: 2] = 2'(code);
    end
    return v;
  endfunction

  task automatic check_all();
    check("lights", 32'(lights), 32'(exp_lights()));
    check("state_o", 32'(state_o), 32'(m_mode));
    check("cur_dir", 32'(cur_dir), 32'(m_dir));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) m_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // Asserted between edges so the asynchronous clear is observed immediately.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1 m_reset();
    check_all();
    check("rst_lights", 32'(lights), 32'h0000_00A8);
    @(negedge clk);
    check_all();
    reset = 1'b1;
  endtask

  initial begin
    bit ok;
    reset = 1'b0; sensor = '0; flash = 1'b0;
    @(negedge clk);
    m_reset();
    check_all();
    check("rst_lights", 32'(lights), 32'h0000_00A8);
    reset = 1'b1;

    run(50);

    do_reset(); sensor = 4'b0100; run(12);

    do_reset(); sensor = 4'b0011; run(30);
    flash = 1'b1; run(20);
    flash = 1'b0; sensor = 4'b0010; run(10);

    do_reset(); sensor = 4'b1011; run(100);

    // Idle long enough for the green timer to saturate, then demand arrives.
    do_reset(); sensor = 4'b0000; run(260);
    sensor = 4'b0011; run(30);

    do_reset(); sensor = 4'b0100;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      cycle();
      ok = (m_mode == MG && m_dir == 2);
    end
    check("wait_dir2_green", 32'(ok), 32'd1);
    sensor = 4'b0001;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      cycle();
      ok = (m_mode == MY);
    end
    check("wait_dir2_yellow", 32'(ok), 32'd1);
    do_reset(); run(10);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) sensor = 4'($urandom);
      if ($urandom_range(0, 79) == 0) flash = ~flash;
      if ($urandom_range(0, 399) == 0) do_reset();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl_multi.md
Name: traffic_ctrl_multi

Overview:
Parametrised successor to the two-road traffic-light FSM. Controls N_DIR approaches with per-approach vehicle sensors, programmable green, yellow and all-red timings, and round-robin fairness with a maximum-green cap. Adds a maintenance flash mode. Sits between the sensor-conditioning logic and the lamp drivers.

Parameters:
N_DIR, 4, number of approaches (>=2)
CNT_W, 8, phase timer width; every timing parameter is < 2**CNT_W
GREEN_MIN, 5, minimum green cycles (>=1)
GREEN_MAX, 20, maximum green cycles when another approach is waiting (>=GREEN_MIN)
YELLOW_T, 2, yellow cycles (>=1)
ALLRED_T, 1, all-red clearance cycles (>=1)
FLASH_T, 4, cycles per half-period in flash mode (>=1)
Localparam DIR_W = max(1, $clog2(N_DIR)).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
sensor  in  N_DIR  vehicle present per approach, synchronous level
flash  in  1  maintenance flash request, level
lights  out  2*N_DIR  lamp code per approach; approach i uses bits [2i+1:2i]
cur_dir  out  DIR_W  approach currently owning (or last owning) green
state_o  out  2  00 GREEN, 01 YELLOW, 10 ALLRED, 11 FLASH

Behaviour:
- Lamp codes: 00 green, 01 yellow, 10 red, 11 off.
- One clock; reset is asynchronous and active-low.
- Reset (reset=0, immediate, any state): state GREEN, cur_dir 0, timer 0, flash phase 0, force0 flag 0. Lights = approach 0 green, all others red (N_DIR=4: 8'b10_10_10_00).
- timer counts cycles spent in the current state: 0 on the first cycle, +1 per cycle, cleared on every state change. It saturates and never wraps.
- other_demand = OR of sensor[j] for all j != cur_dir.
- GREEN: lights[cur_dir] = 00, others 10. Leave to YELLOW at an edge where timer >= GREEN_MIN-1 && other_demand && (!sensor[cur_dir] || timer >= GREEN_MAX-1). Green therefore lasts GREEN_MIN..GREEN_MAX cycles when demand exists. With no other demand, green holds indefinitely.
- YELLOW: lights[cur_dir] = 01, others 10. Lasts exactly YELLOW_T cycles, then ALLRED.
- ALLRED: all approaches 10. Lasts exactly ALLRED_T cycles, then GREEN. At the exit edge, cur_dir is updated:
  - if force0 is set: cur_dir = 0, force0 cleared;
  - else: cur_dir = first index k in cur_dir+1, cur_dir+2, ... (mod N_DIR, excluding cur_dir) with sensor[k]=1, sampled at that edge;
  - if none is set: cur_dir = (cur_dir+1) mod N_DIR.
- FLASH: flash=1 sampled at any edge in any state moves to FLASH next cycle, timer 0, phase 0. This has priority over all other transitions.
  - phase 0: all approaches 01; phase 1: all approaches 11.
  - phase toggles and timer clears when timer = FLASH_T-1.
  - flash=0 at an edge in FLASH -> ALLRED with force0 set, so green resumes on approach 0.
- cur_dir holds through YELLOW, ALLRED (until exit) and FLASH.
- Outputs are registered or decoded purely from registered state; no combinational path from sensor or flash to lights.
- Simultaneous events: flash beats every timer expiry; the sensor value at the ALLRED exit edge alone decides the next direction.

Test Plan:
- Reset then sensor=0, flash=0 for 50 cycles -> lights=8'b10_10_10_00, state_o=00, cur_dir=0 throughout.
- sensor=4'b0100 from reset release -> 5 cycles green on dir0, 2 cycles yellow (lights=8'b10_10_10_01), 1 cycle 8'hAA, then cur_dir=2 and lights=8'b10_00_10_10.
- sensor=4'b0011 held -> dir0 green exactly 20 cycles (GREEN_MAX cap), then yellow, all-red, then dir1 green.
- sensor=4'b1011 held -> green order dir0 -> dir1 -> dir3 -> dir0 (round robin; dir2 skipped), each green 20 cycles.
- flash=1 during dir1 green for 20 cycles -> next cycle all 01 for 4 cycles, all 11 for 4 cycles, alternating. flash=0 -> 1 cycle 8'hAA, then dir0 green, even with sensor=4'b0010.
- reset=0 asserted mid-YELLOW on dir2 -> same cycle, asynchronously: lights=8'b10_10_10_00, state_o=00, cur_dir=0. After release, timer restarts from 0.
